// File: rtl/ctr_seq_checker.sv
// Receive-side sequence checker for a WIDTH-bit free-running count stream.
// It locks onto the +1 sequence, counts misses while locked, and drops lock after repeated misses.
module ctr_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_err,
  output logic [1:0]       state,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err_pulse,
  output logic             lost_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_V  = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d, expected_q, nextPrev;
  logic [3:0]       match_q, match_d, miss_q, miss_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             errPulse_q, errPulse_d, lost_q, lost_d, locked_q;
  logic             isMatch;

  assign nextPrev = prev_q + WIDTH'(1);
  assign isMatch  = (data_in == nextPrev);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_d      = err_q;
    errPulse_d = 1'b0;
    lost_d     = 1'b0;
    if (sample_en) begin
      case (state_q)
        SEARCH: begin
          prev_d  = data_in;
          match_d = 4'd0;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          prev_d = data_in;
          if (isMatch) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_V) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          if (isMatch) begin
            prev_d = data_in;
            miss_d = 4'd0;
          end else begin
            // Flywheel on the prediction so one glitched sample costs exactly one error.
            prev_d     = nextPrev;
            errPulse_d = 1'b1;
            err_d      = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
            miss_d     = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOSS_V) begin
              state_d = SEARCH;
              lost_d  = 1'b1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (clear_err) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      err_q      <= '0;
      errPulse_q <= 1'b0;
      lost_q     <= 1'b0;
      locked_q   <= 1'b0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      errPulse_q <= errPulse_d;
      lost_q     <= lost_d;
      locked_q   <= (state_d == LOCKED);
      // The prediction only moves with accepted samples, so it reads 0 until the first one.
      if (sample_en) expected_q <= prev_d + WIDTH'(1);
    end
  end

  assign state      = state_q;
  assign locked     = locked_q;
  assign expected   = expected_q;
  assign err_pulse  = errPulse_q;
  assign lost_pulse = lost_q;
  assign err_count  = err_q;

  paramLegal: assert property (@(posedge clk)
    (LOCK_CNT >= 1) && (LOCK_CNT <= 15) && (LOSS_CNT >= 1) && (LOSS_CNT <= 15));

endmodule

// File: tb/tb_ctr_seq_checker.sv
// Scoreboard bench for ctr_seq_checker: directed vectors push expected responses,
// a monitor pops and compares them one cycle after each stimulus cycle.
module tb_ctr_seq_checker;

  typedef struct packed {
    logic [1:0] st;
    logic       lk;
    logic [3:0] ex;
    logic       ep;
    logic       lp;
    logic [3:0] ec;
  } resp_t;

  localparam logic [1:0] S_SEARCH = 2'd0, S_ACQ = 2'd1, S_LOCK = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       clear_err = 1'b0;
  logic [1:0] state;
  logic       locked;
  logic [3:0] expected;
  logic       err_pulse;
  logic       lost_pulse;
  logic [3:0] err_count;

  resp_t expQ[$];
  string nameQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  ctr_seq_checker #(.WIDTH(4), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(4)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .data_in(data_in),
    .clear_err(clear_err), .state(state), .locked(locked), .expected(expected),
    .err_pulse(err_pulse), .lost_pulse(lost_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] d,
                               input logic clr, input logic [1:0] st, input logic [3:0] ex,
                               input logic ep, input logic lp, input logic [3:0] ec,
                               input string nm);
    resp_t r;
    @(negedge clk);
    reset = rst;
    sample_en = en;
    data_in = d;
    clear_err = clr;
    r.st = st;
    r.lk = (st == S_LOCK);
    r.ex = ex;
    r.ep = ep;
    r.lp = lp;
    r.ec = ec;
    expQ.push_back(r);
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input resp_t e, input string nm);
    resp_t a;
    a = '{st: state, lk: locked, ex: expected, ep: err_pulse, lp: lost_pulse, ec: err_count};
    testsRun++;
    if (a !== e) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state=%0d locked=%0b expected=%0d err_pulse=%0b lost_pulse=%0b err_count=%0d, want state=%0d locked=%0b expected=%0d err_pulse=%0b lost_pulse=%0b err_count=%0d",
               nm, a.st, a.lk, a.ex, a.ep, a.lp, a.ec, e.st, e.lk, e.ex, e.ep, e.lp, e.ec);
    end
  endtask

  // Monitor: the response to each stimulus cycle is registered at the following posedge.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput(expQ.pop_front(), nameQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e;
    int cnt;
    // Reset state
    applyStimulus(1, 0, 4'd0, 0, S_SEARCH, 4'd0, 0, 0, 4'd0, "reset0");
    applyStimulus(1, 1, 4'd9, 0, S_SEARCH, 4'd0, 0, 0, 4'd0, "resetPriority");

    // Clean stream 0..4 locks the cycle after sample 4
    applyStimulus(0, 1, 4'd0, 0, S_ACQ,  4'd1, 0, 0, 4'd0, "acq0");
    applyStimulus(0, 1, 4'd1, 0, S_ACQ,  4'd2, 0, 0, 4'd0, "acq1");
    applyStimulus(0, 1, 4'd2, 0, S_ACQ,  4'd3, 0, 0, 4'd0, "acq2");
    applyStimulus(0, 1, 4'd3, 0, S_ACQ,  4'd4, 0, 0, 4'd0, "acq3");
    applyStimulus(0, 1, 4'd4, 0, S_LOCK, 4'd5, 0, 0, 4'd0, "lock4");
    // Through the 15->0 wrap and on to prev=6
    for (int v = 5; v <= 22; v++)
      applyStimulus(0, 1, 4'(v % 16), 0, S_LOCK, 4'((v + 1) % 16), 0, 0, 4'd0, "wrapStream");

    // Single glitch: 9 presented when 7 expected
    applyStimulus(0, 1, 4'd9, 0, S_LOCK, 4'd8, 1, 0, 4'd1, "glitch9");
    applyStimulus(0, 1, 4'd8, 0, S_LOCK, 4'd9, 0, 0, 4'd1, "recover8");

    // Three consecutive misses drop lock
    applyStimulus(0, 1, 4'd0, 0, S_LOCK,   4'd10, 1, 0, 4'd2, "miss1");
    applyStimulus(0, 1, 4'd0, 0, S_LOCK,   4'd11, 1, 0, 4'd3, "miss2");
    applyStimulus(0, 1, 4'd0, 0, S_SEARCH, 4'd12, 1, 1, 4'd4, "miss3Lost");
    // Relock after 1+4 clean samples
    applyStimulus(0, 1, 4'd5, 0, S_ACQ,  4'd6,  0, 0, 4'd4, "relock5");
    applyStimulus(0, 1, 4'd6, 0, S_ACQ,  4'd7,  0, 0, 4'd4, "relock6");
    applyStimulus(0, 1, 4'd7, 0, S_ACQ,  4'd8,  0, 0, 4'd4, "relock7");
    applyStimulus(0, 1, 4'd8, 0, S_ACQ,  4'd9,  0, 0, 4'd4, "relock8");
    applyStimulus(0, 1, 4'd9, 0, S_LOCK, 4'd10, 0, 0, 4'd4, "relock9");

    // Gapped stream: only enabled samples count, gaps show no pulses
    applyStimulus(1, 0, 4'd0, 0, S_SEARCH, 4'd0, 0, 0, 4'd0, "resetGap");
    applyStimulus(0, 1, 4'd3, 0, S_ACQ,  4'd4, 0, 0, 4'd0, "gap3");
    applyStimulus(0, 0, 4'd7, 0, S_ACQ,  4'd4, 0, 0, 4'd0, "gapHoldA");
    applyStimulus(0, 1, 4'd4, 0, S_ACQ,  4'd5, 0, 0, 4'd0, "gap4");
    applyStimulus(0, 0, 4'd0, 0, S_ACQ,  4'd5, 0, 0, 4'd0, "gapHoldB");
    applyStimulus(0, 1, 4'd5, 0, S_ACQ,  4'd6, 0, 0, 4'd0, "gap5");
    applyStimulus(0, 0, 4'd1, 0, S_ACQ,  4'd6, 0, 0, 4'd0, "gapHoldC");
    applyStimulus(0, 1, 4'd6, 0, S_ACQ,  4'd7, 0, 0, 4'd0, "gap6");
    applyStimulus(0, 0, 4'd2, 0, S_ACQ,  4'd7, 0, 0, 4'd0, "gapHoldD");
    applyStimulus(0, 1, 4'd7, 0, S_LOCK, 4'd8, 0, 0, 4'd0, "gapLock7");
    applyStimulus(0, 0, 4'd0, 0, S_LOCK, 4'd8, 0, 0, 4'd0, "gapLockedHold");

    // Twenty isolated glitches saturate the 4-bit error counter at 15
    e = 8;
    for (int i = 0; i < 20; i++) begin
      cnt = (i + 1 > 15) ? 15 : i + 1;
      applyStimulus(0, 1, 4'((e + 5) % 16), 0, S_LOCK, 4'((e + 1) % 16), 1, 0, 4'(cnt), "satGlitch");
      applyStimulus(0, 1, 4'((e + 1) % 16), 0, S_LOCK, 4'((e + 2) % 16), 0, 0, 4'(cnt), "satMatch");
      e = (e + 2) % 16;
    end
    // clear_err coincident with a glitch wins over the increment
    applyStimulus(0, 1, 4'((e + 5) % 16), 1, S_LOCK, 4'((e + 1) % 16), 1, 0, 4'd0, "clearOnGlitch");
    applyStimulus(0, 1, 4'((e + 1) % 16), 0, S_LOCK, 4'((e + 2) % 16), 0, 0, 4'd0, "clearMatch");
    e = (e + 2) % 16;
    applyStimulus(0, 1, 4'((e + 5) % 16), 0, S_LOCK, 4'((e + 1) % 16), 1, 0, 4'd1, "postClearGlitch");
    applyStimulus(0, 1, 4'((e + 1) % 16), 0, S_LOCK, 4'((e + 2) % 16), 0, 0, 4'd1, "postClearMatch");
    e = (e + 2) % 16;

    // Reset mid-lock with a mismatching sample: no lost_pulse, no err_pulse
    applyStimulus(1, 1, 4'((e + 7) % 16), 0, S_SEARCH, 4'd0, 0, 0, 4'd0, "resetMidLock");
    applyStimulus(0, 0, 4'd0, 0, S_SEARCH, 4'd0, 0, 0, 4'd0, "idleAfterReset");

    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboardDrain: %0d entries left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
